// File: rtl/mag_comp_pkg.sv
// Shared types for the pipelined magnitude comparator: compare-result struct
// and the bit positions of its flags.
package mag_comp_pkg;

    localparam int CMP_LT_BIT = 2;
    localparam int CMP_EQ_BIT = 1;
    localparam int CMP_GT_BIT = 0;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

endpackage

// File: rtl/mag_cmp_core.sv
// Combinational signed/unsigned magnitude compare of a against b, producing
// the extended difference and the resolved lt/eq/gt flags.
module mag_cmp_core
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH:0]   diff,
    output cmp_res_t         res
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    // One extra bit keeps the difference exact for both signed and unsigned
    // operands, so its top bit is the borrow/sign of a-b.
    always_comb begin
        a_ext  = {is_signed & a[WIDTH-1], a};
        b_ext  = {is_signed & b[WIDTH-1], b};
        diff   = a_ext - b_ext;
        res.lt = diff[WIDTH];
        res.eq = (diff == {(WIDTH+1){1'b0}});
        res.gt = ~res.lt & ~res.eq;
    end

endmodule

// File: rtl/mag_comp_pipe.sv
// Two-stage valid/ready magnitude comparator with running max/min/count
// statistics over the delivered A operands.
module mag_comp_pipe
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_gte,
    output logic [WIDTH-1:0] out_a,
    input  logic             clr_stats,
    output logic             stat_valid,
    output logic [WIDTH-1:0] stat_max,
    output logic [WIDTH-1:0] stat_min,
    output logic [CNT_W-1:0] stat_count
);

    logic             adv1;
    logic             adv2;
    logic             out_xfer;

    logic             s1_valid;
    logic [WIDTH:0]   s1_diff;
    logic [WIDTH-1:0] s1_a;
    logic             s1_signed;

    logic             s2_valid;
    cmp_res_t         s2_res;
    logic             s2_gte;
    logic [WIDTH-1:0] s2_a;
    logic             s2_signed;

    logic [WIDTH:0]   in_diff;
    cmp_res_t         in_res;
    cmp_res_t         nxt_res;
    logic [WIDTH:0]   max_diff;
    cmp_res_t         max_res;
    logic [WIDTH:0]   min_diff;
    cmp_res_t         min_res;
    logic             unused_bits;

    mag_cmp_core #(.WIDTH(WIDTH)) u_cmp_in (
        .a         (in_a),
        .b         (in_b),
        .is_signed (in_signed),
        .diff      (in_diff),
        .res       (in_res)
    );

    mag_cmp_core #(.WIDTH(WIDTH)) u_cmp_max (
        .a         (s2_a),
        .b         (stat_max),
        .is_signed (s2_signed),
        .diff      (max_diff),
        .res       (max_res)
    );

    mag_cmp_core #(.WIDTH(WIDTH)) u_cmp_min (
        .a         (s2_a),
        .b         (stat_min),
        .is_signed (s2_signed),
        .diff      (min_diff),
        .res       (min_res)
    );

    // Stage 1 only needs the difference; its flags are re-derived from the registered diff.
    assign unused_bits = ^{in_res, max_diff, min_diff, max_res.lt, max_res.eq,
                           min_res.eq, min_res.gt};

    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;
    assign out_xfer = s2_valid & out_ready;

    assign out_valid = s2_valid;
    assign out_lt    = s2_res.lt;
    assign out_eq    = s2_res.eq;
    assign out_gt    = s2_res.gt;
    assign out_gte   = s2_gte;
    assign out_a     = s2_a;

    // Resolve the stage-2 flags from the registered difference.
    always_comb begin
        nxt_res.lt = s1_diff[WIDTH];
        nxt_res.eq = (s1_diff == {(WIDTH+1){1'b0}});
        nxt_res.gt = ~nxt_res.lt & ~nxt_res.eq;
    end

    // Stage 1 register: difference, operand A and mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_diff   <= {(WIDTH+1){1'b0}};
            s1_a      <= {WIDTH{1'b0}};
            s1_signed <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_diff   <= in_diff;
                s1_a      <= in_a;
                s1_signed <= in_signed;
            end
        end
    end

    // Stage 2 register: presented result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_res    <= 3'b000;
            s2_gte    <= 1'b0;
            s2_a      <= {WIDTH{1'b0}};
            s2_signed <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res    <= nxt_res;
                s2_gte    <= ~nxt_res.lt;
                s2_a      <= s1_a;
                s2_signed <= s1_signed;
            end
        end
    end

    // Statistics: a clear wins over a concurrent transfer, which then reseeds.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_valid <= 1'b0;
            stat_max   <= {WIDTH{1'b0}};
            stat_min   <= {WIDTH{1'b0}};
            stat_count <= {CNT_W{1'b0}};
        end else if (out_xfer && (clr_stats || !stat_valid)) begin
            stat_valid <= 1'b1;
            stat_max   <= s2_a;
            stat_min   <= s2_a;
            stat_count <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (clr_stats) begin
            stat_valid <= 1'b0;
            stat_max   <= {WIDTH{1'b0}};
            stat_min   <= {WIDTH{1'b0}};
            stat_count <= {CNT_W{1'b0}};
        end else if (out_xfer) begin
            if (max_res.gt) begin
                stat_max <= s2_a;
            end
            if (min_res.lt) begin
                stat_min <= s2_a;
            end
            if (stat_count != {CNT_W{1'b1}}) begin
                stat_count <= stat_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mag_comp_pipe.sv
// Scoreboard bench for mag_comp_pipe: a driver pushes hand-computed expected
// results; a monitor pops and compares on every output transfer.
module tb_mag_comp_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = 8'h00;
    logic [W-1:0]  in_b = 8'h00;
    logic          in_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_lt, out_eq, out_gt, out_gte;
    logic [W-1:0]  out_a;
    logic          clr_stats = 1'b0;
    logic          stat_valid;
    logic [W-1:0]  stat_max, stat_min;
    logic [CW-1:0] stat_count;

    typedef struct {
        logic [7:0] a;
        logic [3:0] f;   // {lt, eq, gt, gte}
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   accepted = 0;

    localparam logic [3:0] F_LT = 4'b1000;
    localparam logic [3:0] F_EQ = 4'b0101;
    localparam logic [3:0] F_GT = 4'b0011;

    mag_comp_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lt     (out_lt),
        .out_eq     (out_eq),
        .out_gt     (out_gt),
        .out_gte    (out_gte),
        .out_a      (out_a),
        .clr_stats  (clr_stats),
        .stat_valid (stat_valid),
        .stat_max   (stat_max),
        .stat_min   (stat_min),
        .stat_count (stat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] f);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb.push_back('{a, f});
            @(posedge clk);
            accepted++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk); #3; n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(negedge clk); #1;
    endtask

    task automatic clear();
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
        #1;
    endtask

    task automatic check_stats(input string tag, input logic v, input logic [7:0] mx,
                               input logic [7:0] mn, input logic [3:0] cnt);
        check({tag, "_valid"}, 32'(stat_valid), 32'(v));
        check({tag, "_max"},   32'(stat_max),   32'(mx));
        check({tag, "_min"},   32'(stat_min),   32'(mn));
        check({tag, "_count"}, 32'(stat_count), 32'(cnt));
    endtask

    // Monitor: compare each output transfer against the scoreboard and check hold stability.
    logic       prev_stall = 1'b0;
    logic [7:0] held_a;
    logic [3:0] held_f;
    exp_t       e;
    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_a", 32'(out_a), 32'(held_a));
                check("hold_flags", 32'({out_lt, out_eq, out_gt, out_gte}), 32'(held_f));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got a=%0h want no result", out_a);
                end else begin
                    e = sb.pop_front();
                    check("res_a", 32'(out_a), 32'(e.a));
                    check("res_flags", 32'({out_lt, out_eq, out_gt, out_gte}), 32'(e.f));
                end
            end
            prev_stall = out_valid && !out_ready;
            held_a     = out_a;
            held_f     = {out_lt, out_eq, out_gt, out_gte};
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({out_lt, out_eq, out_gt, out_gte}), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check_stats("rst", 1'b0, 8'h00, 8'h00, 4'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Signed vs unsigned, with latency check on the first pair
        out_ready = 1'b1;
        send(8'h80, 8'h7F, 1'b1, F_LT);
        @(negedge clk); in_valid = 1'b0; #1;
        check("lat_n1", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        check("lat_n2", 32'(out_valid), 32'd1);
        send(8'h80, 8'h7F, 1'b0, F_GT);
        send(8'h55, 8'h55, 1'b0, F_EQ);
        send(8'h7F, 8'h80, 1'b1, F_GT);
        idle();
        drain();

        // Backpressure: 4 back-to-back pairs while the consumer stalls
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(8'd1, 8'd2, 1'b0, F_LT);
                send(8'd2, 8'd2, 1'b0, F_EQ);
                send(8'd3, 8'd2, 1'b0, F_GT);
                send(8'd4, 8'd2, 1'b0, F_GT);
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_accepts", 32'(accepted), 32'd2);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Statistics, signed
        clear();
        check_stats("clr", 1'b0, 8'h00, 8'h00, 4'd0);
        send(8'd5,  8'd0, 1'b1, F_GT);
        send(8'hFD, 8'd0, 1'b1, F_LT);
        send(8'd100, 8'd0, 1'b1, F_GT);
        idle();
        drain();
        check_stats("sgn", 1'b1, 8'd100, 8'hFD, 4'd3);

        // Statistics, unsigned
        clear();
        send(8'hFD, 8'd0, 1'b0, F_GT);
        send(8'd5,  8'd0, 1'b0, F_GT);
        idle();
        drain();
        check_stats("uns", 1'b1, 8'hFD, 8'd5, 4'd2);

        // Clear colliding with an output transfer
        out_ready = 1'b0;
        send(8'd7, 8'd7, 1'b0, F_EQ);
        idle();
        @(negedge clk); #1;
        check("coll_pending", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        #1;
        check_stats("coll", 1'b1, 8'd7, 8'd7, 4'd1);

        // Counter saturation over 20 transfers
        clear();
        for (int i = 0; i < 20; i++) begin
            send(8'(i), 8'd10, 1'b0, (i < 10) ? F_LT : ((i == 10) ? F_EQ : F_GT));
        end
        idle();
        drain();
        check_stats("sat", 1'b1, 8'd19, 8'd0, 4'd15);

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, F_LT);
        send(8'h33, 8'h22, 1'b0, F_GT);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        sb.delete();
        @(negedge clk); #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_flags", 32'({out_lt, out_eq, out_gt, out_gte}), 32'd0);
        check_stats("mid_rst", 1'b0, 8'h00, 8'h00, 4'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("post_rst_quiet", 32'(out_valid), 32'd0);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
